uart_xcvr: RTL

UART_XCVR -- requirements
Module: uart_xcvr

---
 rtl/uart_xcvr_if.sv | 25 ++
 rtl/uart_xcvr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr_if.sv
// uart_xcvr_if: parallel-side handshake bundle of the UART transceiver
// master: user logic (drives tx_data/tx_valid, consumes RX results)
// slave:  uart_xcvr (drives tx_ready and the registered RX outputs)
// tx_data/tx_valid/tx_ready   transmit byte and valid/ready handshake
// rx_data/rx_valid            received payload and its one-clk strobe
// rx_frame_err/rx_parity_err  frame status, held until the next rx_valid
interface uart_xcvr_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transmitter/receiver sharing one oversampling baud tick
// clk  system clock, all state on its rising edge
// rst  asynchronous active-high reset
// bus  uart_xcvr_if.slave: tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_frame_err/rx_parity_err
// tx   serial output, idle high
// rx   serial input, asynchronous to clk
// Define UART_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1) to both directions.
module uart_xcvr #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    uart_xcvr_if.slave bus,
    output logic       tx,
    input  logic       rx
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] DB_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] SB_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD     = 1'(PARITY_ODD);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          run;
    assign tick = div_cnt == DW'(DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            run     <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            run     <= 1'b1;
        end
    end
    tx_state_t            tx_state, tx_state_d;
    logic [OW-1:0]        tx_os, tx_os_d;
    logic [BW-1:0]        tx_bit, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_end;
    // tx_end marks the last tick of the bit currently on the line
    assign tx_end       = tick && tx_os == OS_LAST;
    // run keeps tx_ready low throughout reset and raises it on the first clock after
    assign bus.tx_ready = run && tx_state == TX_IDLE;
    assign tx = tx_state == TX_START  ? 1'b0 :
                tx_state == TX_DATA   ? tx_shift[0] :
                tx_state == TX_PARITY ? tx_par : 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_os    <= tx_os_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_par   <= tx_par_d;
        end
    end
    always_comb begin
        tx_state_d = tx_state;
        tx_os_d    = (tx_state == TX_IDLE || tx_end) ? '0 : tick ? tx_os + 1'b1 : tx_os;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_par_d   = tx_par;
        case (tx_state)
            TX_IDLE: if (bus.tx_valid && bus.tx_ready) begin
                tx_state_d = TX_START;
                tx_shift_d = bus.tx_data;
                tx_par_d   = ^bus.tx_data ^ ODD;
            end
            TX_START: if (tx_end) tx_state_d = TX_DATA;
            TX_DATA: if (tx_end) begin
                tx_shift_d = tx_shift >> 1;
                tx_bit_d   = tx_bit == DB_LAST ? '0 : tx_bit + 1'b1;
                if (tx_bit == DB_LAST) tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_end) tx_state_d = TX_STOP;
            TX_STOP: if (tx_end) begin
                tx_bit_d = tx_bit == SB_LAST ? '0 : tx_bit + 1'b1;
                if (tx_bit == SB_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end
    logic                 rx_s1, rx_s2;
    rx_state_t            rx_state, rx_state_d;
    logic [OW-1:0]        rx_os, rx_os_d;
    logic [BW-1:0]        rx_bit, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic                 rx_par, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_d, rx_ferr_d, rx_perr_d;
    logic                 rx_mid, rx_end;
    // START counts to the start-bit middle; every later bit is sampled one full bit after that
    assign rx_mid = tick && rx_os == OS_MID;
    assign rx_end = tick && rx_os == OS_LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rx_s2, rx_s1}    <= 2'b11;
            rx_state          <= RX_IDLE;
            rx_os             <= '0;
            rx_bit            <= '0;
            rx_shift          <= '0;
            rx_par            <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
        end else begin
            {rx_s2, rx_s1}    <= {rx_s1, rx};
            rx_state          <= rx_state_d;
            rx_os             <= rx_os_d;
            rx_bit            <= rx_bit_d;
            rx_shift          <= rx_shift_d;
            rx_par            <= rx_par_d;
            bus.rx_data       <= rx_data_d;
            bus.rx_valid      <= rx_valid_d;
            bus.rx_frame_err  <= rx_ferr_d;
            bus.rx_parity_err <= rx_perr_d;
        end
    end
    always_comb begin
        rx_state_d = rx_state;
        rx_os_d    = tick ? rx_os + 1'b1 : rx_os;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_par_d   = rx_par;
        rx_data_d  = bus.rx_data;
        rx_valid_d = 1'b0;
        rx_ferr_d  = bus.rx_frame_err;
        rx_perr_d  = bus.rx_parity_err;
        case (rx_state)
            RX_IDLE: begin
                rx_os_d = '0;
                if (!rx_s2) rx_state_d = RX_START;
            end
            RX_START: if (rx_mid) begin
                rx_os_d    = '0;
                rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_end) begin
                rx_os_d    = '0;
                rx_shift_d = {rx_s2, rx_shift[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit == DB_LAST ? '0 : rx_bit + 1'b1;
                if (rx_bit == DB_LAST) rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_end) begin
                rx_os_d    = '0;
                rx_par_d   = rx_s2;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_end) begin
                rx_os_d    = '0;
                rx_data_d  = rx_shift;
                rx_valid_d = 1'b1;
                rx_ferr_d  = !rx_s2;
                rx_perr_d  = PAR_EN && (rx_par != (^rx_shift ^ ODD));
                rx_state_d = rx_s2 ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                rx_os_d = '0;
                if (rx_s2) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end
endmodule
